sevenseg_mux_driver: RTL and testbench

SEVENSEG_MUX_DRIVER -- requirements
Module: sevenseg_mux_driver

---
 rtl/sevenseg_mux_driver.sv | 133 +++++++++++++
 tb/tb_sevenseg_mux_driver.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_mux_driver.sv
// Time-multiplexed seven-segment driver: scans NUM_DIGITS digits from a shadowed
// nibble register with blanking, decimal points and leading-zero suppression.
module sevenseg_mux_driver #(
   parameter int NUM_DIGITS = 4,
   parameter int SCAN_DIV   = 8192,
   parameter bit HEX_MODE   = 1'b1
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [4*NUM_DIGITS-1:0] value,
   input  logic                    load,
   input  logic [NUM_DIGITS-1:0]   blank,
   input  logic [NUM_DIGITS-1:0]   dp,
   input  logic                    lz_blank,
   output logic [NUM_DIGITS-1:0]   DIGIT,
   output logic [0:6]              DISPLAY,
   output logic                    DP,
   output logic                    scan_tick
);

   localparam int CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SCAN_DIV - 1);
   localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(NUM_DIGITS - 1);
   localparam logic [0:6] SEG_DARK = 7'b1111111;
   localparam logic [0:6] SEG_DASH = 7'b1111110;

   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [4*NUM_DIGITS-1:0] shadow_q, shadow_d;
   logic [NUM_DIGITS-1:0]   digit_q, digit_d;
   logic [0:6]              display_q, display_d;
   logic                    dp_q, dp_d;
   logic                    adv_q;
   logic                    tick_q;

   logic [NUM_DIGITS-1:0]   zeroRun;
   logic                    allZero;
   logic [3:0]              nibSel;
   logic                    blankSel;
   logic                    dpSel;
   logic                    runSel;
   logic                    dark;

   function automatic logic [0:6] segCode(input logic [3:0] nib);
      logic [0:6] seg;
      case (nib)
         4'h0:    seg = 7'b0000001;
         4'h1:    seg = 7'b1001111;
         4'h2:    seg = 7'b0010010;
         4'h3:    seg = 7'b0000110;
         4'h4:    seg = 7'b1001100;
         4'h5:    seg = 7'b0100100;
         4'h6:    seg = 7'b0100000;
         4'h7:    seg = 7'b0001111;
         4'h8:    seg = 7'b0000000;
         4'h9:    seg = 7'b0000100;
         4'hA:    seg = 7'b0001000;
         4'hB:    seg = 7'b1100000;
         4'hC:    seg = 7'b0110001;
         4'hD:    seg = 7'b1000010;
         4'hE:    seg = 7'b0110000;
         default: seg = 7'b0111000;
      endcase
      if (!HEX_MODE && nib > 4'h9) seg = SEG_DASH;
      return seg;
   endfunction

   // zeroRun[i] is set when nibble i and every more significant nibble are zero
   always_comb begin
      zeroRun = '0;
      allZero = 1'b1;
      for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
         allZero    = allZero & (shadow_q[4*i +: 4] == 4'h0);
         zeroRun[i] = allZero;
      end
   end

   always_comb begin
      nibSel   = 4'h0;
      blankSel = 1'b0;
      dpSel    = 1'b0;
      runSel   = 1'b0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == IDX_W'(i)) begin
            nibSel   = shadow_q[4*i +: 4];
            blankSel = blank[i];
            dpSel    = dp[i];
            runSel   = zeroRun[i];
         end
      end

      dark      = blankSel | (lz_blank & (idx_q != '0) & runSel);
      display_d = dark ? SEG_DARK : segCode(nibSel);
      dp_d      = dark ? 1'b1 : ~dpSel;
      digit_d   = ~(NUM_DIGITS'(1) << idx_q);

      cnt_d    = (cnt_q == CNT_MAX) ? '0 : cnt_q + 1'b1;
      idx_d    = idx_q;
      if (cnt_q == CNT_MAX) idx_d = (idx_q == IDX_MAX) ? '0 : idx_q + 1'b1;
      shadow_d = load ? value : shadow_q;
   end

   // Outputs are registered from the current idx, so the tick is delayed one
   // extra stage to line up with the first cycle of the new digit.
   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q     <= '0;
         idx_q     <= '0;
         shadow_q  <= '0;
         digit_q   <= '1;
         display_q <= SEG_DARK;
         dp_q      <= 1'b1;
         adv_q     <= 1'b0;
         tick_q    <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         digit_q   <= digit_d;
         display_q <= display_d;
         dp_q      <= dp_d;
         adv_q     <= (cnt_q == CNT_MAX);
         tick_q    <= adv_q;
      end
   end

   assign DIGIT     = digit_q;
   assign DISPLAY   = display_q;
   assign DP        = dp_q;
   assign scan_tick = tick_q;

endmodule

// File: tb/tb_sevenseg_mux_driver.sv
// Scoreboard bench for sevenseg_mux_driver: two instances (hex and dash glyph
// modes) share inputs; hand-written glyph tables give the expected outputs.
module tb_sevenseg_mux_driver;

   localparam logic [0:6] S0   = 7'b0000001;
   localparam logic [0:6] S1   = 7'b1001111;
   localparam logic [0:6] S2   = 7'b0010010;
   localparam logic [0:6] S3   = 7'b0000110;
   localparam logic [0:6] S4   = 7'b1001100;
   localparam logic [0:6] S5   = 7'b0100100;
   localparam logic [0:6] S6   = 7'b0100000;
   localparam logic [0:6] S7   = 7'b0001111;
   localparam logic [0:6] S8   = 7'b0000000;
   localparam logic [0:6] S9   = 7'b0000100;
   localparam logic [0:6] SA   = 7'b0001000;
   localparam logic [0:6] SC   = 7'b0110001;
   localparam logic [0:6] SF   = 7'b0111000;
   localparam logic [0:6] DASH = 7'b1111110;
   localparam logic [0:6] DK   = 7'b1111111;

   typedef struct {
      logic [3:0] dig;
      logic [0:6] segA;
      logic [0:6] segB;
      logic       dpo;
      logic       tick;
      string      name;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] value = 16'h0000;
   logic        load = 1'b0;
   logic [3:0]  blankIn = 4'b0000;
   logic [3:0]  dpIn = 4'b0000;
   logic        lzBlank = 1'b0;
   logic [3:0]  digitA, digitB;
   logic [0:6]  dispA, dispB;
   logic        dpOutA, dpOutB;
   logic        tickA, tickB;

   exp_t        expQ[$];
   int          checks = 0;
   int          errors = 0;
   int          k = 0;
   logic [0:6]  glyphA [4];
   logic [0:6]  glyphB [4];
   logic        dpExp [4];

   sevenseg_mux_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1'b1)) dutHex (
      .clk(clk), .reset(reset), .value(value), .load(load), .blank(blankIn),
      .dp(dpIn), .lz_blank(lzBlank), .DIGIT(digitA), .DISPLAY(dispA),
      .DP(dpOutA), .scan_tick(tickA)
   );

   sevenseg_mux_driver #(.NUM_DIGITS(4), .SCAN_DIV(4), .HEX_MODE(1'b0)) dutDash (
      .clk(clk), .reset(reset), .value(value), .load(load), .blank(blankIn),
      .dp(dpIn), .lz_blank(lzBlank), .DIGIT(digitB), .DISPLAY(dispB),
      .DP(dpOutB), .scan_tick(tickB)
   );

   always #5 clk = ~clk;

   // Called at a negedge after inputs are set; each pushed entry describes the
   // outputs after the coming posedge. k counts output cycles since reset release.
   task automatic applyStimulus(input string name, input int n);
      exp_t e;
      int   idx;
      for (int c = 0; c < n; c++) begin
         k++;
         idx    = ((k - 1) / 4) % 4;
         e.dig  = ~(4'b0001 << idx);
         e.segA = glyphA[idx];
         e.segB = glyphB[idx];
         e.dpo  = dpExp[idx];
         e.tick = (k > 1) && ((k - 1) % 4 == 0);
         e.name = name;
         expQ.push_back(e);
         @(negedge clk);
      end
   endtask

   task automatic holdReset(input string name, input int n);
      exp_t e;
      reset = 1'b1;
      k = 0;
      for (int c = 0; c < n; c++) begin
         e.dig  = 4'b1111;
         e.segA = DK;
         e.segB = DK;
         e.dpo  = 1'b1;
         e.tick = 1'b0;
         e.name = name;
         expQ.push_back(e);
         @(negedge clk);
      end
   endtask

   task automatic checkOutput(input exp_t e);
      checks++;
      if (digitA !== e.dig || digitB !== e.dig || dispA !== e.segA || dispB !== e.segB ||
          dpOutA !== e.dpo || dpOutB !== e.dpo || tickA !== e.tick || tickB !== e.tick) begin
         errors++;
         $display("[TB] FAIL %s k=%0d: got DIGIT=%b/%b DISPLAY=%b/%b DP=%b/%b tick=%b/%b, expected DIGIT=%b DISPLAY=%b/%b DP=%b tick=%b",
                  e.name, k, digitA, digitB, dispA, dispB, dpOutA, dpOutB, tickA, tickB,
                  e.dig, e.segA, e.segB, e.dpo, e.tick);
      end
   endtask

   // Monitor: one expectation per clock, sampled just after the edge
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (expQ.size() > 0) begin
            e = expQ.pop_front();
            checkOutput(e);
         end
      end
   end

   initial begin
      int guard;
      glyphA = '{S0, S0, S0, S0};
      glyphB = '{S0, S0, S0, S0};
      dpExp  = '{1'b1, 1'b1, 1'b1, 1'b1};
      @(negedge clk);
      holdReset("reset", 2);

      reset = 1'b0; value = 16'h1234; load = 1'b1;
      applyStimulus("release", 1);
      load = 1'b0;
      glyphA = '{S4, S3, S2, S1};
      glyphB = '{S4, S3, S2, S1};
      applyStimulus("scan1234", 19);

      value = 16'h00A0; load = 1'b1; lzBlank = 1'b1;
      applyStimulus("load00A0", 1);
      load = 1'b0;
      glyphA = '{S0, SA, DK, DK};
      glyphB = '{S0, DASH, DK, DK};
      applyStimulus("lzOn", 16);
      lzBlank = 1'b0;
      glyphA = '{S0, SA, S0, S0};
      glyphB = '{S0, DASH, S0, S0};
      applyStimulus("lzOff", 16);

      blankIn = 4'b0010; dpIn = 4'b0011;
      glyphA = '{S0, DK, S0, S0};
      glyphB = '{S0, DK, S0, S0};
      dpExp  = '{1'b0, 1'b1, 1'b1, 1'b1};
      applyStimulus("blankDp", 16);
      dpIn = 4'b1111; lzBlank = 1'b1;
      glyphA = '{S0, DK, DK, DK};
      glyphB = '{S0, DK, DK, DK};
      applyStimulus("darkForcesDp", 16);

      blankIn = 4'b0000; dpIn = 4'b0000; lzBlank = 1'b0;
      glyphA = '{S0, SA, S0, S0};
      glyphB = '{S0, DASH, S0, S0};
      dpExp  = '{1'b1, 1'b1, 1'b1, 1'b1};
      applyStimulus("liveClear", 4);
      value = 16'hFC95; load = 1'b1;
      applyStimulus("loadFC95", 1);
      load = 1'b0;
      glyphA = '{S5, S9, SC, SF};
      glyphB = '{S5, S9, DASH, DASH};
      applyStimulus("hexVsDash", 16);

      value = 16'h0000;
      applyStimulus("noLoad", 8);
      value = 16'h8765; load = 1'b1;
      applyStimulus("load8765", 1);
      load = 1'b0;
      glyphA = '{S5, S6, S7, S8};
      glyphB = '{S5, S6, S7, S8};
      applyStimulus("scan8765", 16);

      guard = 0;
      while (!(((k / 4) % 4 == 2) && (k % 4 == 1)) && guard < 32) begin
         applyStimulus("walkToDigit2", 1);
         guard++;
      end
      value = 16'h1234; load = 1'b1;
      holdReset("midResetLoad", 1);
      load = 1'b0;
      holdReset("midReset", 1);
      reset = 1'b0;
      glyphA = '{S0, S0, S0, S0};
      glyphB = '{S0, S0, S0, S0};
      applyStimulus("afterReset", 8);

      guard = 0;
      while (expQ.size() > 0 && guard < 5) begin
         @(negedge clk);
         guard++;
      end
      if (expQ.size() > 0) begin
         errors++;
         $display("[TB] FAIL drain: %0d expectations left, required 0", expQ.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
